// File: rtl/cpu_pkg.sv
// Shared decode constants, decoded-instruction struct and decode helper for operand fetch.
// Latency: none (constants and a pure function).
// Backpressure: none.
package cpu_pkg;

    localparam int REG_AW = 5;

    // ALU control encodings understood by the downstream registered ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef struct packed {
        logic [3:0]        alu_ctl;
        logic [REG_AW-1:0] dest;     // 0 means no writeback
        logic              uses_rt;  // rt is a source operand (hazard check)
        logic              use_imm;  // B comes from the extended immediate
        logic              sext;     // sign-extend rather than zero-extend imm16
        logic              bad;      // unsupported encoding
    } dec_t;

    function automatic dec_t decode(input logic [5:0]        opcode,
                                    input logic [5:0]        funct,
                                    input logic [REG_AW-1:0] rt,
                                    input logic [REG_AW-1:0] rd);
        dec_t d;
        d.alu_ctl = ALU_BAD;
        d.dest    = '0;
        d.uses_rt = 1'b0;
        d.use_imm = 1'b0;
        d.sext    = 1'b0;
        d.bad     = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                // every R-type reads rt, even an unsupported funct
                d.uses_rt = 1'b1;
                d.dest    = rd;
                d.bad     = 1'b0;
                case (funct)
                    F_ADD:   d.alu_ctl = ALU_ADD;
                    F_SUB:   d.alu_ctl = ALU_SUB;
                    F_AND:   d.alu_ctl = ALU_AND;
                    F_OR:    d.alu_ctl = ALU_OR;
                    F_NOR:   d.alu_ctl = ALU_NOR;
                    F_SLT:   d.alu_ctl = ALU_SLT;
                    default: begin
                        d.alu_ctl = ALU_BAD;
                        d.dest    = '0;
                        d.bad     = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: begin
                d.dest    = rt;
                d.use_imm = 1'b1;
                d.sext    = (opcode != OP_ANDI) && (opcode != OP_ORI);
                d.bad     = 1'b0;
                d.alu_ctl = (opcode == OP_SLTI) ? ALU_SLT :
                            (opcode == OP_ANDI) ? ALU_AND :
                            (opcode == OP_ORI)  ? ALU_OR  : ALU_ADD;
            end
            OP_SW: begin
                // address = rs + simm; rt is the store data, so it is a source
                d.uses_rt = 1'b1;
                d.use_imm = 1'b1;
                d.sext    = 1'b1;
                d.bad     = 1'b0;
                d.alu_ctl = ALU_ADD;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file, 2 combinational read ports, 1 synchronous write port, r0 reads as zero.
// Latency: reads 0 cycles; a write is visible from the cycle after its edge (same cycle with WB_BYPASS_EN).
// Backpressure: none; writes always land. Build option WB_BYPASS_EN forwards write data to matching reads.
module regfile_2r1w
    #(
        parameter int NREG = 32,
        parameter int DW   = 32,
        parameter int AW   = 5
    )(
        input  logic          clk,
        input  logic          rst_n,
        input  logic [AW-1:0] ra0,
        input  logic [AW-1:0] ra1,
        output logic [DW-1:0] rd0,
        output logic [DW-1:0] rd1,
        input  logic          we,
        input  logic [AW-1:0] wa,
        input  logic [DW-1:0] wd
    );

    logic [DW-1:0] mem [NREG];

    // Storage: synchronous clear, writes to r0 dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    // Read ports: r0 forced to zero, optional same-cycle forwarding of the write port
    always_comb begin
        rd0 = (ra0 == '0) ? '0 : mem[ra0];
        rd1 = (ra1 == '0) ? '0 : mem[ra1];
`ifdef WB_BYPASS_EN
        if (we && (wa != '0) && (wa == ra0)) rd0 = wd;
        if (we && (wa != '0) && (wa == ra1)) rd1 = wd;
`endif
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand stage: decodes opcode/funct, reads regfile, interlocks on pending writes, registers A/B/ALUcontrol.
// Latency: operands 1 cycle after accept; res_valid/res_dest 1 cycle after the op leaves (aligned with ALU C).
// Backpressure: valid/ready; output frozen while out_valid && !out_ready. Build option WB_BYPASS_EN enables write forwarding.
module operand_fetch
    import cpu_pkg::*;
    #(
        parameter int NREG = 32,
        parameter int DW   = 32
    )(
        input  logic              clk,
        input  logic              rst_n,
        input  logic              in_valid,
        output logic              in_ready,
        input  logic [5:0]        opcode,
        input  logic [5:0]        funct,
        input  logic [REG_AW-1:0] rs,
        input  logic [REG_AW-1:0] rt,
        input  logic [REG_AW-1:0] rd,
        input  logic [15:0]       imm16,
        output logic              out_valid,
        input  logic              out_ready,
        output logic [DW-1:0]     A,
        output logic [DW-1:0]     B,
        output logic [3:0]        ALUcontrol,
        output logic              illegal,
        output logic              res_valid,
        output logic [REG_AW-1:0] res_dest,
        input  logic              wb_en,
        input  logic [REG_AW-1:0] wb_addr,
        input  logic [DW-1:0]     wb_data
    );

    dec_t              dec;
    logic [DW-1:0]     rs_dat;
    logic [DW-1:0]     rt_dat;
    logic [DW-1:0]     imm_ext;
    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_eff;
    logic [NREG-1:0]   clr_mask;
    logic [NREG-1:0]   set_mask;
    logic              stall;
    logic              accept;
    logic              out_fire;
    logic [REG_AW-1:0] out_dest;

    regfile_2r1w #(
        .NREG (NREG),
        .DW   (DW),
        .AW   (REG_AW)
    ) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra0   (rs),
        .ra1   (rt),
        .rd0   (rs_dat),
        .rd1   (rt_dat),
        .we    (wb_en),
        .wa    (wb_addr),
        .wd    (wb_data)
    );

    // Decode and immediate extension
    always_comb begin
        dec     = decode(opcode, funct, rt, rd);
        imm_ext = dec.sext ? {{(DW-16){imm16[15]}}, imm16} : {{(DW-16){1'b0}}, imm16};
    end

    // Scoreboard masks, hazard detection and handshake
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wb_en) clr_mask[wb_addr] = 1'b1;
`ifdef WB_BYPASS_EN
        // the concurrent writeback is forwarded, so its pending bit no longer blocks
        pend_eff = pend & ~clr_mask;
`else
        // the read sees the old value; wait until the write has landed
        pend_eff = pend;
`endif
        stall    = in_valid && (((rs != '0) && pend_eff[rs]) ||
                                (dec.uses_rt && (rt != '0) && pend_eff[rt]));
        in_ready = rst_n && !stall && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        if (accept && (dec.dest != '0)) set_mask[dec.dest] = 1'b1;
    end

    // Scoreboard: a set on the same edge as a clear wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr_mask) | set_mask;
        end
    end

    // Output register and result-tag delay
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            A          <= '0;
            B          <= '0;
            ALUcontrol <= ALU_AND;
            illegal    <= 1'b0;
            out_dest   <= '0;
            res_valid  <= 1'b0;
            res_dest   <= '0;
        end else begin
            if (accept) begin
                out_valid  <= 1'b1;
                A          <= rs_dat;
                B          <= dec.use_imm ? imm_ext : rt_dat;
                ALUcontrol <= dec.alu_ctl;
                illegal    <= dec.bad;
                out_dest   <= dec.dest;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
            res_valid <= out_fire;
            res_dest  <= out_fire ? out_dest : '0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A, B;
    logic [3:0]  ALUcontrol;
    logic        illegal;
    logic        res_valid;
    logic [4:0]  res_dest;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    operand_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .funct      (funct),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm16      (imm16),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .A          (A),
        .B          (B),
        .ALUcontrol (ALUcontrol),
        .illegal    (illegal),
        .res_valid  (res_valid),
        .res_dest   (res_dest),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  s, t, d;
        logic [15:0] imm;
        logic [31:0] ea, eb;
        logic [3:0]  ectl;
        logic        eill;
        logic [4:0]  edest;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d, input logic [15:0] imm);
        opcode = op; funct = fn; rs = s; rt = t; rd = d; imm16 = imm;
    endtask

    task automatic wb(input logic [4:0] addr, input logic [31:0] data);
        wb_en = 1'b1; wb_addr = addr; wb_data = data;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic preload();
        wb(5'd1, 32'd5);
        wb(5'd2, 32'd3);
        wb(5'd0, 32'h0000DEAD);
    endtask

    initial begin
        // in-flight ops cleared by reset; first vectors read r1=5, r2=3, r0 after a DEAD write
        vecs[0]  = '{"add",    6'h00, 6'h20, 5'd1, 5'd2, 5'd3,  16'h0000, 32'd5, 32'd3,         4'b0010, 1'b0, 5'd3};
        vecs[1]  = '{"sub",    6'h00, 6'h22, 5'd1, 5'd2, 5'd6,  16'h0000, 32'd5, 32'd3,         4'b0110, 1'b0, 5'd6};
        vecs[2]  = '{"and",    6'h00, 6'h24, 5'd1, 5'd2, 5'd7,  16'h0000, 32'd5, 32'd3,         4'b0000, 1'b0, 5'd7};
        vecs[3]  = '{"or",     6'h00, 6'h25, 5'd1, 5'd2, 5'd8,  16'h0000, 32'd5, 32'd3,         4'b0001, 1'b0, 5'd8};
        vecs[4]  = '{"nor",    6'h00, 6'h27, 5'd1, 5'd2, 5'd9,  16'h0000, 32'd5, 32'd3,         4'b1100, 1'b0, 5'd9};
        vecs[5]  = '{"slt",    6'h00, 6'h2A, 5'd2, 5'd1, 5'd10, 16'h0000, 32'd3, 32'd5,         4'b0111, 1'b0, 5'd10};
        vecs[6]  = '{"addi",   6'h08, 6'h00, 5'd0, 5'd4, 5'd0,  16'hFFFF, 32'd0, 32'hFFFFFFFF,  4'b0010, 1'b0, 5'd4};
        vecs[7]  = '{"ori",    6'h0D, 6'h00, 5'd0, 5'd4, 5'd0,  16'hFFFF, 32'd0, 32'h0000FFFF,  4'b0001, 1'b0, 5'd4};
        vecs[8]  = '{"slti",   6'h0A, 6'h00, 5'd1, 5'd11, 5'd0, 16'h8000, 32'd5, 32'hFFFF8000,  4'b0111, 1'b0, 5'd11};
        vecs[9]  = '{"andi",   6'h0C, 6'h00, 5'd1, 5'd12, 5'd0, 16'h80F0, 32'd5, 32'h000080F0,  4'b0000, 1'b0, 5'd12};
        vecs[10] = '{"lw",     6'h23, 6'h00, 5'd1, 5'd13, 5'd0, 16'h0004, 32'd5, 32'd4,         4'b0010, 1'b0, 5'd13};
        vecs[11] = '{"sw",     6'h2B, 6'h00, 5'd1, 5'd2, 5'd0,  16'hFFF8, 32'd5, 32'hFFFFFFF8,  4'b0010, 1'b0, 5'd0};
        vecs[12] = '{"op3F",   6'h3F, 6'h00, 5'd0, 5'd0, 5'd0,  16'h1234, 32'd0, 32'd0,         4'b1111, 1'b1, 5'd0};
        vecs[13] = '{"badfn",  6'h00, 6'h3F, 5'd1, 5'd2, 5'd5,  16'h0000, 32'd5, 32'd3,         4'b1111, 1'b1, 5'd0};
        vecs[14] = '{"add_r2", 6'h00, 6'h20, 5'd2, 5'd2, 5'd14, 16'h0000, 32'd3, 32'd3,         4'b0010, 1'b0, 5'd14};
        vecs[15] = '{"add_r0", 6'h00, 6'h20, 5'd0, 5'd0, 5'd15, 16'h0000, 32'd0, 32'd0,         4'b0010, 1'b0, 5'd15};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0);

        // ---- reset with a valid instruction presented
        #1;
        in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clk);
            chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
            chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_A",         A,                  32'd0);
            chk("rst_B",         B,                  32'd0);
            chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
            chk("rst_ctl",       {28'b0, ALUcontrol}, 32'd0);
            chk("rst_illegal",   {31'b0, illegal},   32'd0);
        end
        tick();
        in_valid = 1'b0;
        rst_n = 1'b1;
        preload();

        // ---- table-driven decode vectors
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].op, vecs[i].fn, vecs[i].s, vecs[i].t, vecs[i].d, vecs[i].imm);
            in_valid = 1'b1;
            @(negedge clk);
            chk({vecs[i].name, ".in_ready"}, {31'b0, in_ready}, 32'd1);
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            chk({vecs[i].name, ".out_valid"}, {31'b0, out_valid}, 32'd1);
            chk({vecs[i].name, ".A"}, A, vecs[i].ea);
            chk({vecs[i].name, ".B"}, B, vecs[i].eb);
            chk({vecs[i].name, ".ctl"}, {28'b0, ALUcontrol}, {28'b0, vecs[i].ectl});
            chk({vecs[i].name, ".illegal"}, {31'b0, illegal}, {31'b0, vecs[i].eill});
            chk({vecs[i].name, ".res_valid_early"}, {31'b0, res_valid}, 32'd0);
            tick();
            @(negedge clk);
            chk({vecs[i].name, ".res_valid"}, {31'b0, res_valid}, 32'd1);
            chk({vecs[i].name, ".res_dest"}, {27'b0, res_dest}, {27'b0, vecs[i].edest});
            tick();
        end

        // ---- RAW interlock on r3
        do_reset();
        preload();
        drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0);
        in_valid = 1'b1;
        tick();
        drive(6'h00, 6'h22, 5'd3, 5'd1, 5'd5, 16'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("raw_stall", {31'b0, in_ready}, 32'd0);
            tick();
        end
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_1234;
        @(negedge clk);
`ifdef WB_BYPASS_EN
        chk("raw_bypass_ready", {31'b0, in_ready}, 32'd1);
        tick();
        wb_en = 1'b0;
        in_valid = 1'b0;
`else
        chk("raw_wb_cycle_stall", {31'b0, in_ready}, 32'd0);
        tick();
        wb_en = 1'b0;
        @(negedge clk);
        chk("raw_late_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
`endif
        @(negedge clk);
        chk("raw_A", A, 32'h0000_1234);
        chk("raw_B", B, 32'd5);
        chk("raw_ctl", {28'b0, ALUcontrol}, 32'b0110);
        tick();
        @(negedge clk);
        chk("raw_res_dest", {27'b0, res_dest}, 32'd5);
        tick();

        // ---- backpressure: hold for 3 cycles
        do_reset();
        preload();
        out_ready = 1'b0;
        drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0);
        in_valid = 1'b1;
        tick();
        drive(6'h00, 6'h25, 5'd1, 5'd2, 5'd6, 16'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_A", A, 32'd5);
            chk("bp_B", B, 32'd3);
            chk("bp_ctl", {28'b0, ALUcontrol}, 32'b0010);
            chk("bp_res_valid", {31'b0, res_valid}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_ctl", {28'b0, ALUcontrol}, 32'b0001);
        chk("bp_res_valid_after", {31'b0, res_valid}, 32'd1);
        chk("bp_res_dest_after", {27'b0, res_dest}, 32'd3);
        tick();

        // ---- reset mid-operation drops the in-flight op
        drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd7, 16'h0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_res_valid", {31'b0, res_valid}, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
